// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter and its scoreboard.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef logic [NREGS-1:0] busy_vec_t;

    function automatic busy_vec_t reg_onehot(input logic [ADDR_W-1:0] r);
        return busy_vec_t'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: busy vector, RAW hazard detect and the optional
// protocol checker enabled by REGFILE_WB_SCOREBOARD_CHECK_EN.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we3,
    input  logic [ADDR_W-1:0] i_wa3,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    input  logic [ADDR_W-1:0] i_chk_ra1,
    input  logic [ADDR_W-1:0] i_chk_ra2,
    input  logic              i_gnt,
    input  logic [ADDR_W-1:0] i_gnt_addr,
    input  logic              i_a_valid,
    input  logic              i_a_ready,
    input  logic              i_b_valid,
    input  logic              i_b_ready,
    output busy_vec_t         o_busy,
    output logic              o_hazard,
    output logic              o_err
);

    busy_vec_t r_busy;
    busy_vec_t w_set;
    busy_vec_t w_clr;
    logic      w_haz1;
    logic      w_haz2;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_rsv_en && i_rsv_addr != ZERO_REG)
            w_set = reg_onehot(i_rsv_addr);
        if (i_we3)
            w_clr = reg_onehot(i_wa3);
    end

    // Set is applied after clear so a same-cycle reservation survives the write.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~reg_onehot(ZERO_REG);
    end

    // The regfile forwards wd3 for the register being written, so that one is not a hazard.
    assign w_haz1 = r_busy[i_chk_ra1] && (i_chk_ra1 != ZERO_REG) && !(i_we3 && i_wa3 == i_chk_ra1);
    assign w_haz2 = r_busy[i_chk_ra2] && (i_chk_ra2 != ZERO_REG) && !(i_we3 && i_wa3 == i_chk_ra2);

    assign o_hazard = w_haz1 | w_haz2;
    assign o_busy   = r_busy;

`ifdef REGFILE_WB_SCOREBOARD_CHECK_EN
    logic r_err;
    logic r_a_pend;
    logic r_b_pend;
    logic w_err_rsv;
    logic w_err_gnt;
    logic w_err_wd;

    assign w_err_rsv = i_rsv_en && (i_rsv_addr != ZERO_REG) && r_busy[i_rsv_addr]
                     && !(i_we3 && i_wa3 == i_rsv_addr);
    assign w_err_gnt = i_gnt && (i_gnt_addr != ZERO_REG) && !r_busy[i_gnt_addr];
    assign w_err_wd  = (r_a_pend && !i_a_valid) || (r_b_pend && !i_b_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_a_pend <= 1'b0;
            r_b_pend <= 1'b0;
        end else begin
            r_a_pend <= i_a_valid && !i_a_ready;
            r_b_pend <= i_b_valid && !i_b_ready;
            r_err    <= r_err | w_err_rsv | w_err_gnt | w_err_wd;
        end
    end

    always @(posedge clk) begin
        if (!reset && (w_err_rsv || w_err_gnt || w_err_wd))
            $error("wb_scoreboard protocol error: rsv=%0b gnt=%0b withdraw=%0b",
                   w_err_rsv, w_err_gnt, w_err_wd);
    end

    assign o_err = r_err;
`else
    logic w_unused;
    assign w_unused = ^{i_gnt, i_gnt_addr, i_a_valid, i_a_ready, i_b_valid, i_b_ready};
    assign o_err    = 1'b0;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the regfile write port with starvation
// guard, registered write stage and pending-write scoreboard (REGFILE_WB_SCOREBOARD_CHECK_EN).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] chk_ra1,
    input  logic [ADDR_W-1:0] chk_ra2,
    output logic              hazard,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic [NREGS-1:0]  busy,
    output logic              err
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve;
    logic                r_we3;
    logic [ADDR_W-1:0]   r_wa3;
    logic [DATA_W-1:0]   r_wd3;
    logic                w_b_wins;
    logic                w_a_gnt;
    logic                w_b_gnt;
    logic                w_gnt;
    wb_req_t             w_req;

    // A has priority unless B has already lost STARVE_MAX times in a row.
    assign w_b_wins = b_valid && (!a_valid || r_starve == STARVE_TOP);
    assign w_a_gnt  = !reset && a_valid && !w_b_wins;
    assign w_b_gnt  = !reset && w_b_wins;
    assign w_gnt    = w_a_gnt | w_b_gnt;
    assign w_req    = w_b_gnt ? wb_req_t'{addr: b_addr, data: b_data}
                              : wb_req_t'{addr: a_addr, data: a_data};

    assign a_ready = w_a_gnt;
    assign b_ready = w_b_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_starve <= '0;
        else if (w_b_gnt || !b_valid)
            r_starve <= '0;
        else if (r_starve != STARVE_TOP)
            r_starve <= r_starve + STARVE_W'(1);
    end

    // A zero-register grant consumes the slot but leaves the write port idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_gnt && (w_req.addr != ZERO_REG);
            if (w_gnt && w_req.addr != ZERO_REG) begin
                r_wa3 <= w_req.addr;
                r_wd3 <= w_req.data;
            end
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_we3      (r_we3),
        .i_wa3      (r_wa3),
        .i_rsv_en   (rsv_en),
        .i_rsv_addr (rsv_addr),
        .i_chk_ra1  (chk_ra1),
        .i_chk_ra2  (chk_ra2),
        .i_gnt      (w_gnt),
        .i_gnt_addr (w_req.addr),
        .i_a_valid  (a_valid),
        .i_a_ready  (w_a_gnt),
        .i_b_valid  (b_valid),
        .i_b_ready  (w_b_gnt),
        .o_busy     (busy),
        .o_hazard   (hazard),
        .o_err      (err)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: behavioural model compared every
// cycle plus directed vectors with hand-computed literal expectations.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int STARVE_MAX = 3;
`ifdef REGFILE_WB_SCOREBOARD_CHECK_EN
    localparam logic EXP_ERR_DOUBLE_RSV = 1'b1;
`else
    localparam logic EXP_ERR_DOUBLE_RSV = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid, rsv_en;
    logic [ADDR_W-1:0] a_addr, b_addr, rsv_addr, chk_ra1, chk_ra2;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, hazard, we3, err;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [NREGS-1:0]  busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
        .hazard(hazard), .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .err(err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the regfile port as seen by the spec's rules.
    logic [NREGS-1:0]  m_busy = '0;
    logic              m_we3  = 1'b0;
    logic [ADDR_W-1:0] m_wa3  = '0;
    logic [DATA_W-1:0] m_wd3  = '0;
    int                m_b_lost = 0;
    logic              m_err  = 1'b0;
    logic              m_a_pend = 1'b0;
    logic              m_b_pend = 1'b0;
    bit                cmp_en = 1'b0;

    function automatic logic exp_b_gnt();
        return !reset && b_valid && (!a_valid || m_b_lost >= STARVE_MAX);
    endfunction

    function automatic logic exp_a_gnt();
        return !reset && a_valid && !exp_b_gnt();
    endfunction

    function automatic logic exp_h(input logic [ADDR_W-1:0] r);
        return m_busy[r] && r != ZERO_REG && !(m_we3 && m_wa3 == r);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = '0; m_we3 = 1'b0; m_wa3 = '0; m_wd3 = '0;
            m_b_lost = 0; m_err = 1'b0; m_a_pend = 1'b0; m_b_pend = 1'b0;
        end else begin
            logic ag, bg, wr;
            logic [ADDR_W-1:0] ga;
            logic [DATA_W-1:0] gd;
            ag = exp_a_gnt();
            bg = exp_b_gnt();
            ga = bg ? b_addr : a_addr;
            gd = bg ? b_data : a_data;
`ifdef REGFILE_WB_SCOREBOARD_CHECK_EN
            if (rsv_en && rsv_addr != ZERO_REG && m_busy[rsv_addr] && !(m_we3 && m_wa3 == rsv_addr))
                m_err = 1'b1;
            if ((ag || bg) && ga != ZERO_REG && !m_busy[ga])
                m_err = 1'b1;
            if ((m_a_pend && !a_valid) || (m_b_pend && !b_valid))
                m_err = 1'b1;
`endif
            m_a_pend = a_valid && !ag;
            m_b_pend = b_valid && !bg;
            if (bg || !b_valid) m_b_lost = 0;
            else if (m_b_lost < STARVE_MAX) m_b_lost++;
            if (m_we3) m_busy[m_wa3] = 1'b0;
            if (rsv_en && rsv_addr != ZERO_REG) m_busy[rsv_addr] = 1'b1;
            wr = (ag || bg) && ga != ZERO_REG;
            m_we3 = wr;
            if (wr) begin
                m_wa3 = ga;
                m_wd3 = gd;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_a_ready", a_ready, exp_a_gnt());
            check("m_b_ready", b_ready, exp_b_gnt());
            check("m_hazard", hazard, exp_h(chk_ra1) | exp_h(chk_ra2));
            check("m_we3", we3, m_we3);
            check("m_wa3", wa3, m_wa3);
            check("m_wd3", wd3, m_wd3);
            check("m_busy", busy, m_busy);
            check("m_err", err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    string seq_exp = "AAABAAABAAAB";

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; rsv_en = 0;
        a_addr = 0; b_addr = 0; rsv_addr = 0; chk_ra1 = 0; chk_ra2 = 0;
        a_data = 0; b_data = 0;
        step();
        cmp_en = 1'b1;
        #2 check("reset_we3", we3, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_wd3", wd3, 0);
        step();
        reset = 1'b0;
        step();

        // Double reservation of x4 without an intervening write.
        rsv_en = 1; rsv_addr = 5'd4;
        step();
        step();
        rsv_en = 0;
        step();
        #2 check("err_double_rsv", err, EXP_ERR_DOUBLE_RSV);
        check("busy4_set", busy[4], 1);
        step();
        step();
        #2 check("err_sticky", err, EXP_ERR_DOUBLE_RSV);
        a_valid = 1; a_addr = 5'd4; a_data = 64'h44;
        step();
        a_valid = 0;
        step();
        step();
        #2 check("busy4_cleared", busy[4], 0);

        // Asynchronous reset while A is requesting.
        step();
        a_valid = 1; a_addr = 5'd5; a_data = 64'h55;
        #1 reset = 1'b1;
        #1 check("rst_a_ready", a_ready, 0);
        check("rst_we3", we3, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        step();
        a_valid = 0;
        step();
        reset = 1'b0;
        step();
        step();
        #2 check("no_write_after_rst", we3, 0);
        rsv_en = 1; rsv_addr = 5'd5;
        step();
        rsv_en = 0; a_valid = 1; a_addr = 5'd5; a_data = 64'h55;
        step();
        a_valid = 0;
        #2 check("represent_we3", we3, 1);
        check("represent_wa3", wa3, 5);
        check("represent_wd3", wd3, 64'h55);

        // Single A write to x7 with forward mask on the hazard.
        step();
        step();
        rsv_en = 1; rsv_addr = 5'd7; chk_ra1 = 5'd7;
        step();
        rsv_en = 0;
        step();
        a_valid = 1; a_addr = 5'd7; a_data = 64'h1234;
        #2 check("haz_t2", hazard, 1);
        check("a_ready_t2", a_ready, 1);
        step();
        a_valid = 0;
        #2 check("we3_t3", we3, 1);
        check("wa3_t3", wa3, 7);
        check("wd3_t3", wd3, 64'h1234);
        check("haz_t3_fwd", hazard, 0);
        check("busy7_t3", busy[7], 1);
        step();
        #2 check("busy7_t4", busy[7], 0);
        check("we3_t4", we3, 0);
        chk_ra1 = 0;

        // Continuous contention between distinct registers.
        step();
        a_valid = 1; a_addr = 5'd10; a_data = 64'hAA;
        b_valid = 1; b_addr = 5'd11; b_data = 64'hBB;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] got;
            #2 got = a_ready ? "A" : (b_ready ? "B" : "-");
            check($sformatf("grant_%0d", i), got, seq_exp[i]);
            step();
        end
        a_valid = 0; b_valid = 0;
        step();
        step();

        // Zero register: slot consumed, no write, never busy, never a hazard.
        b_valid = 1; b_addr = ZERO_REG; b_data = 64'hFFFF;
        #2 check("zero_b_ready", b_ready, 1);
        step();
        b_valid = 0;
        #2 check("zero_we3", we3, 0);
        check("zero_wa3_hold", wa3, 11);
        check("zero_wd3_hold", wd3, 64'hBB);
        check("zero_busy", busy[31], 0);
        rsv_en = 1; rsv_addr = ZERO_REG; chk_ra1 = ZERO_REG;
        step();
        rsv_en = 0;
        #2 check("zero_rsv_busy", busy[31], 0);
        check("zero_hazard", hazard, 0);
        chk_ra1 = 0;

        // Set and clear of x9 in the same cycle: set wins.
        step();
        rsv_en = 1; rsv_addr = 5'd9;
        step();
        rsv_en = 0; a_valid = 1; a_addr = 5'd9; a_data = 64'h99;
        step();
        a_valid = 0; rsv_en = 1; rsv_addr = 5'd9;
        #2 check("coll_we3", we3, 1);
        check("coll_wa3", wa3, 9);
        step();
        rsv_en = 0;
        #2 check("coll_busy9", busy[9], 1);
        chk_ra2 = 5'd9;
        #1 check("coll_haz9", hazard, 1);
        step();
        chk_ra2 = 0;
        step();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
